// File: rtl/fpu_rr_sched.sv
// Round-robin front end that shares one fp_12 add/sub datapath between NREQ clients.
// Operands are registered onto the FPU and a tag pipeline returns each result with its owner's ID.
module fpu_rr_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int FPU_LAT = 0,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic                 fpu_op,
  input  logic [31:0]          fpu_c,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_c,
  output logic                 busy,
  output logic [CNTW-1:0]      issue_cnt
);

  logic [IDW-1:0]            ptr;
  logic [IDW-1:0]            gnt_id;
  logic                      gnt_any;
  logic [FPU_LAT:0]          tag_v;
  logic [FPU_LAT:0][IDW-1:0] tag_id;

  // Scan from the requester after the last winner, wrapping, and take the first valid one.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (!rst && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!gnt_any && req_valid[(int'(ptr) + k) % NREQ]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'((int'(ptr) + k) % NREQ);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= 1'b0;
      ptr       <= IDW'(NREQ - 1);
      issue_cnt <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
    end else begin
      if (gnt_any) begin
        fpu_a     <= req_a[32*int'(gnt_id) +: 32];
        fpu_b     <= req_b[32*int'(gnt_id) +: 32];
        fpu_op    <= req_op[gnt_id];
        ptr       <= gnt_id;
        issue_cnt <= issue_cnt + CNTW'(1);
      end
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int k = 1; k <= FPU_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      // fpu_c is valid exactly when the last tag stage carries a live operation.
      rsp_valid <= tag_v[FPU_LAT];
      if (tag_v[FPU_LAT]) begin
        rsp_id <= tag_id[FPU_LAT];
        rsp_c  <= fpu_c;
      end
    end
  end

  assign busy = (|tag_v) | rsp_valid;

endmodule

// File: tb/tb_fpu_rr_sched.sv
// Scoreboard bench: dut0 uses default parameters with a combinational fp_12 stand-in,
// dut1 uses FPU_LAT=2 / CNTW=4 with a two-stage registered stand-in.
module tb_fpu_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         rst0, rst1, hold;
  logic [3:0]   valid0, valid1, ready0, ready1;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_op;
  logic [31:0]  fpu_a0, fpu_b0, fpu_c0, rsp_c0, fpu_a1, fpu_b1, fpu_c1, rsp_c1;
  logic         fpu_op0, fpu_op1, rsp_valid0, rsp_valid1, busy0, busy1;
  logic [1:0]   rsp_id0, rsp_id1;
  logic [15:0]  issue_cnt0;
  logic [3:0]   issue_cnt1;

  // Hand-computed fp32 vectors: 18+17, 18-17, -18+17, -1+-1.
  logic [31:0] vec_a  [4] = '{32'h41900000, 32'h41900000, 32'hC1900000, 32'hBF800000};
  logic [31:0] vec_b  [4] = '{32'h41880000, 32'h41880000, 32'h41880000, 32'hBF800000};
  logic        vec_op [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] vec_c  [4] = '{32'h420C0000, 32'h3F800000, 32'hBF800000, 32'hC0000000};
  int          slot_vec [4];

  typedef struct {
    logic [31:0] id;
    logic [31:0] c;
    int          due;
  } exp_t;
  exp_t exp0[$];
  exp_t exp1[$];

  int checks = 0;
  int fails  = 0;

  // Stand-in for fp_12 that knows only the hand-computed vectors.
  function automatic logic [31:0] fpmodel(logic [31:0] a, logic [31:0] b, logic op);
    logic [31:0] r;
    r = 32'h7FC00000;
    for (int i = 0; i < 4; i++)
      if (a == vec_a[i] && b == vec_b[i] && op == vec_op[i]) r = vec_c[i];
    return r;
  endfunction

  assign fpu_c0 = fpmodel(fpu_a0, fpu_b0, fpu_op0);

  logic [31:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= fpmodel(fpu_a1, fpu_b1, fpu_op1);
    pipe2 <= pipe1;
  end
  assign fpu_c1 = pipe2;

  fpu_rr_sched dut0 (
    .clk(clk), .rst(rst0), .hold(hold), .req_valid(valid0), .req_ready(ready0),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_a(fpu_a0), .fpu_b(fpu_b0), .fpu_op(fpu_op0), .fpu_c(fpu_c0),
    .rsp_valid(rsp_valid0), .rsp_id(rsp_id0), .rsp_c(rsp_c0),
    .busy(busy0), .issue_cnt(issue_cnt0)
  );

  fpu_rr_sched #(.NREQ(4), .IDW(2), .FPU_LAT(2), .CNTW(4)) dut1 (
    .clk(clk), .rst(rst1), .hold(1'b0), .req_valid(valid1), .req_ready(ready1),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_a(fpu_a1), .fpu_b(fpu_b1), .fpu_op(fpu_op1), .fpu_c(fpu_c1),
    .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_c(rsp_c1),
    .busy(busy1), .issue_cnt(issue_cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors pop one expectation per response pulse, including the cycle it was due.
  always @(negedge clk) begin
    if (rsp_valid0 === 1'b1) begin
      if (exp0.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL sb0_unexpected: got id %0d c %h, expected no response", rsp_id0, rsp_c0);
      end else begin
        exp_t e;
        e = exp0.pop_front();
        checkOutput("rsp0_id", 32'(rsp_id0), e.id);
        checkOutput("rsp0_c", rsp_c0, e.c);
        checkOutput("rsp0_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid1 === 1'b1) begin
      if (exp1.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL sb1_unexpected: got id %0d c %h, expected no response", rsp_id1, rsp_c1);
      end else begin
        exp_t e;
        e = exp1.pop_front();
        checkOutput("rsp1_id", 32'(rsp_id1), e.id);
        checkOutput("rsp1_c", rsp_c1, e.c);
        checkOutput("rsp1_cycle", cyc, e.due);
      end
    end
  end

  function automatic int idOf(logic [3:0] onehot);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (onehot[i]) r = i;
    return r;
  endfunction

  task automatic loadSlot(input int s, input int v);
    req_a[32*s +: 32] = vec_a[v];
    req_b[32*s +: 32] = vec_b[v];
    req_op[s]         = vec_op[v];
    slot_vec[s]       = v;
  endtask

  task automatic applyStimulus(input logic [3:0] v0, input logic [3:0] v1, input logic h);
    valid0 = v0;
    valid1 = v1;
    hold   = h;
    #1;
  endtask

  task automatic issue0(input logic [3:0] v, input logic [3:0] exp_ready);
    exp_t e;
    applyStimulus(v, 4'b0000, 1'b0);
    checkOutput("ready0", 32'(ready0), 32'(exp_ready));
    if (exp_ready != 4'b0000) begin
      e.id  = 32'(idOf(exp_ready));
      e.c   = vec_c[slot_vec[idOf(exp_ready)]];
      e.due = cyc + 2;
      exp0.push_back(e);
    end
  endtask

  task automatic issue1(input logic [3:0] v, input logic [3:0] exp_ready, input bit push);
    exp_t e;
    applyStimulus(4'b0000, v, 1'b0);
    checkOutput("ready1", 32'(ready1), 32'(exp_ready));
    if (push && exp_ready != 4'b0000) begin
      e.id  = 32'(idOf(exp_ready));
      e.c   = vec_c[slot_vec[idOf(exp_ready)]];
      e.due = cyc + 4;
      exp1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; hold = 1'b0;
    valid0 = '0; valid1 = '0; req_a = '0; req_b = '0; req_op = '0;
    for (int s = 0; s < 4; s++) loadSlot(s, s);

    // Reset state and combinational ready suppression.
    @(negedge clk);
    @(negedge clk);
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    checkOutput("ready0_in_rst", 32'(ready0), 32'h0);
    checkOutput("ready1_in_rst", 32'(ready1), 32'h0);
    checkOutput("rst_fpu_a", fpu_a0, 32'h0);
    checkOutput("rst_fpu_b", fpu_b0, 32'h0);
    checkOutput("rst_fpu_op", 32'(fpu_op0), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid0), 32'h0);
    checkOutput("rst_rsp_id", 32'(rsp_id0), 32'h0);
    checkOutput("rst_rsp_c", rsp_c0, 32'h0);
    checkOutput("rst_busy", 32'(busy0), 32'h0);
    checkOutput("rst_issue_cnt", 32'(issue_cnt0), 32'h0);
    rst0 = 1'b0; rst1 = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Single add, then single subtract, on requester 0.
    @(negedge clk);
    loadSlot(0, 0);
    issue0(4'b0001, 4'b0001);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("fpu_a", fpu_a0, 32'h41900000);
    checkOutput("fpu_b", fpu_b0, 32'h41880000);
    checkOutput("fpu_op_add", 32'(fpu_op0), 32'h0);
    checkOutput("busy_inflight", 32'(busy0), 32'h1);
    @(negedge clk);
    loadSlot(0, 1);
    issue0(4'b0001, 4'b0001);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("fpu_op_sub", 32'(fpu_op0), 32'h1);

    // Sign cases on requester 2, back to back.
    @(negedge clk);
    loadSlot(2, 2);
    issue0(4'b0100, 4'b0100);
    @(negedge clk);
    loadSlot(2, 3);
    issue0(4'b0100, 4'b0100);
    idle(4);

    // Fairness from a fresh reset: all four requesting for 8 cycles.
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    for (int s = 0; s < 4; s++) loadSlot(s, s);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      issue0(4'b1111, 4'(1 << (k % 4)));
    end
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("issue_cnt_8", 32'(issue_cnt0), 32'd8);
    idle(3);

    // Hold and drain.
    @(negedge clk);
    issue0(4'b0010, 4'b0010);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      applyStimulus(4'b1000, 4'b0000, 1'b1);
      checkOutput("ready0_hold", 32'(ready0), 32'h0);
      checkOutput("busy_drain", 32'(busy0), (k < 3) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    issue0(4'b1010, 4'b1000);
    idle(4);

    // dut1: reset mid-flight discards in-flight ops and restores priority to requester 0.
    @(negedge clk);
    issue1(4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    issue1(4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    rst1 = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    checkOutput("ready1_rst", 32'(ready1), 32'h0);
    @(negedge clk);
    rst1 = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("rst1_rsp_valid", 32'(rsp_valid1), 32'h0);
    checkOutput("rst1_busy", 32'(busy1), 32'h0);
    checkOutput("rst1_fpu_a", fpu_a1, 32'h0);
    checkOutput("rst1_fpu_b", fpu_b1, 32'h0);
    checkOutput("rst1_fpu_op", 32'(fpu_op1), 32'h0);
    checkOutput("rst1_rsp_id", 32'(rsp_id1), 32'h0);
    checkOutput("rst1_rsp_c", rsp_c1, 32'h0);
    checkOutput("rst1_issue_cnt", 32'(issue_cnt1), 32'h0);
    @(negedge clk);
    issue1(4'b0011, 4'b0001, 1'b1);
    idle(6);

    // dut1: 17 issues wrap the 4-bit counter to 1.
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      issue1(4'b0001, 4'b0001, 1'b1);
    end
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("issue_cnt_wrap", 32'(issue_cnt1), 32'd1);
    idle(8);

    checkOutput("sb0_drained", 32'(exp0.size()), 32'd0);
    checkOutput("sb1_drained", 32'(exp1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fpu_rr_sched.md
Name: fpu_rr_sched

Overview:
- Round-robin scheduler that shares one fp_12 add/subtract datapath between NREQ requesters.
- Accepts at most one operation per cycle over a valid/ready handshake and drives registered operands and op onto the FPU.
- Tracks the issuing requester through a fixed-latency tag pipeline and returns each result with the requester's ID.
- Sits between the client blocks and the shared fp_12 instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- FPU_LAT, 0, FPU cycles from the operand register to a valid fpu_c. 0 means a combinational fp_12. Legal range 0..4.
- CNTW, 16, width of the issue counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  when 1, no new grants are made; in-flight operations still drain.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*32  operand A per requester; slice i = bits [32i+31:32i].
- req_b  in  NREQ*32  operand B per requester, same packing as req_a.
- req_op  in  NREQ  per-requester op: 0 = add, 1 = subtract (a-b).
- fpu_a  out  32  registered operand A to fp_12.
- fpu_b  out  32  registered operand B to fp_12.
- fpu_op  out  1  registered op to fp_12.
- fpu_c  in  32  result from fp_12.
- rsp_valid  out  1  result valid; single-cycle pulse per operation; no backpressure.
- rsp_id  out  IDW  index of the requester that owns rsp_c.
- rsp_c  out  32  result value.
- busy  out  1  1 while any operation is in flight.
- issue_cnt  out  CNTW  total accepted operations; wraps modulo 2^CNTW.

Behaviour:
- Reset (rst=1 at an edge):
  - fpu_a, fpu_b, fpu_op, rsp_valid, rsp_id, rsp_c, issue_cnt are cleared to 0.
  - The tag pipeline is cleared to all-invalid, so busy=0.
  - The RR pointer is set to NREQ-1, making requester 0 highest priority.
  - req_ready is forced to 0 combinationally while rst=1.
  - Operations in flight when reset asserts are discarded; no rsp_valid is produced for them.
- Arbitration (combinational):
  - When hold=0 and rst=0, grant the first i with req_valid[i]=1, scanning from ptr+1 upward and wrapping modulo NREQ.
  - req_ready[i]=1 only for that i. Nothing is granted when no req_valid is set or hold=1.
  - req_ready may depend on req_valid in the same cycle. Requesters must not make req_valid depend on req_ready.
- Issue, at an edge where requester g is granted:
  - fpu_a<=req_a[g], fpu_b<=req_b[g], fpu_op<=req_op[g].
  - ptr<=g, and issue_cnt increments.
  - Tag {valid=1, id=g} enters stage 0 of the tag pipeline.
- Idle cycles: fpu_a, fpu_b, fpu_op hold their last values, ptr is unchanged, and a tag with valid=0 enters the pipeline.
- Tag pipeline: FPU_LAT+1 stages, shifting every cycle with no stall.
- Latency: an operation accepted at edge E produces a response on the registered outputs after edge E+FPU_LAT+1.
  - At that edge rsp_valid<=1, rsp_id<=g, and rsp_c<=fpu_c sampled at that edge.
  - Default FPU_LAT=0: a grant in cycle t gives rsp_valid in cycle t+2 (one cycle on fpu_*, then the registered response).
- rsp_valid is 0 in every other cycle; rsp_id and rsp_c hold their last values.
- Throughput: one operation per cycle sustained. Back-to-back grants give back-to-back rsp_valid pulses, in issue order.
- busy is 1 when any tag stage is valid or rsp_valid=1, so busy stays high through the response cycle.
- hold asserted mid-stream stops new grants immediately (same cycle); accepted operations complete normally.
- Only one requester is granted per cycle.
  - A requester that keeps req_valid high after its own grant gets its next grant only after every other active requester has had one.
  - A single active requester is granted every cycle.
- issue_cnt wraps from 2^CNTW-1 to 0 with no flag.

Test Plan:
- Single op, FPU_LAT=0: req_valid[0] with a=0x41900000 (18), b=0x41880000 (17), op=0 → req_ready[0] in the same cycle; fpu_a/fpu_b/fpu_op show the operands one cycle later; rsp_valid=1, rsp_id=0, rsp_c=0x420C0000 (35) two cycles after the grant. Repeat with op=1 → rsp_c=0x3F800000 (1.0).
- Sign cases on requester 2:
  - a=0xC1900000 (-18), b=0x41880000 (17), op=0 → rsp_c=0xBF800000 (-1), rsp_id=2.
  - a=0xBF800000 (-1), b=0xBF800000 (-1), op=0 → rsp_c=0xC0000000 (-2).
- Fairness: all four req_valid held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order on consecutive cycles; issue_cnt=8.
- Hold and drain: grant requester 1, raise hold the next cycle with req_valid[3]=1 → req_ready stays 0 while hold=1; the requester-1 response still arrives; busy falls the cycle after rsp_valid; after hold is released, requester 3 is granted first.
- Reset mid-flight, FPU_LAT=2: grant two ops, assert rst for 1 cycle before their responses are due → no rsp_valid ever appears for them; all outputs are 0 and busy=0; the next grant goes to requester 0 even if ptr was 0 before reset.
- Counter wrap, CNTW=4: issue 17 operations → issue_cnt reads 1.
